// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the multi-cycle RV32I core. It sequences each instruction through
// IF/ID/EX/MEM/WB, drives every datapath strobe and select, and tracks retirement and halt.
module multicycle_control_fsm #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [6:0]       opcode,
  input  logic             bcond,
  input  logic             halt_req,
  input  logic             mem_ready,
  output logic             mem_read,
  output logic             mem_write,
  output logic             i_or_d,
  output logic             ir_write,
  output logic             mdr_write,
  output logic             alu_out_write,
  output logic             reg_write,
  output logic             pc_write,
  output logic [1:0]       pc_source,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic             alu_sel,
  output logic [1:0]       wb_sel,
  output logic             halted,
  output logic [CNT_W-1:0] retired
);

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  typedef enum logic [2:0] {
    S_IF   = 3'd0,
    S_ID   = 3'd1,
    S_EX   = 3'd2,
    S_MEM  = 3'd3,
    S_WB   = 3'd4,
    S_HALT = 3'd5
  } state_t;

  state_t state, next_state;
  logic   count_en;

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IF;
      retired <= '0;
    end else begin
      state <= next_state;
      if (count_en) retired <= retired + CNT_W'(1);
    end
  end

  // Everything is held at zero while reset is high, so an abandoned instruction never commits.
  always_comb begin
    next_state    = S_IF;
    mem_read      = 1'b0;
    mem_write     = 1'b0;
    i_or_d        = 1'b0;
    ir_write      = 1'b0;
    mdr_write     = 1'b0;
    alu_out_write = 1'b0;
    reg_write     = 1'b0;
    pc_write      = 1'b0;
    pc_source     = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_sel       = 1'b0;
    wb_sel        = 2'd0;
    halted        = 1'b0;
    if (!reset) begin
      unique case (state)
        S_IF: begin
          mem_read   = 1'b1;
          ir_write   = mem_ready;
          next_state = mem_ready ? S_ID : S_IF;
        end
        S_ID: begin
          alu_src_b     = 2'd1;
          alu_out_write = 1'b1;
          case (opcode)
            OP_ECALL: begin
              if (halt_req) next_state = S_HALT;
              else pc_write = 1'b1;
            end
            OP_JAL: next_state = S_WB;
            OP_R, OP_I, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR: next_state = S_EX;
            default: pc_write = 1'b1;
          endcase
        end
        S_EX: begin
          alu_src_a = 1'b1;
          case (opcode)
            OP_R: begin
              alu_sel       = 1'b1;
              alu_out_write = 1'b1;
              next_state    = S_WB;
            end
            OP_I: begin
              alu_src_b     = 2'd1;
              alu_sel       = 1'b1;
              alu_out_write = 1'b1;
              next_state    = S_WB;
            end
            OP_LOAD, OP_STORE, OP_JALR: begin
              alu_src_b     = 2'd1;
              alu_out_write = 1'b1;
              next_state    = (opcode == OP_JALR) ? S_WB : S_MEM;
            end
            // ALUOut still holds PC+imm from ID, so a taken branch jumps through it.
            OP_BRANCH: begin
              alu_sel   = 1'b1;
              pc_write  = 1'b1;
              pc_source = bcond ? 2'd2 : 2'd0;
            end
            default: pc_write = 1'b1;
          endcase
        end
        S_MEM: begin
          i_or_d = 1'b1;
          case (opcode)
            OP_LOAD: begin
              mem_read   = 1'b1;
              mdr_write  = mem_ready;
              next_state = mem_ready ? S_WB : S_MEM;
            end
            OP_STORE: begin
              mem_write  = 1'b1;
              pc_write   = mem_ready;
              next_state = mem_ready ? S_IF : S_MEM;
            end
            default: pc_write = 1'b1;
          endcase
        end
        S_WB: begin
          reg_write = 1'b1;
          pc_write  = 1'b1;
          case (opcode)
            OP_LOAD: wb_sel = 2'd1;
            OP_JAL, OP_JALR: begin
              wb_sel    = 2'd2;
              pc_source = 2'd2;
            end
            default: wb_sel = 2'd0;
          endcase
        end
        S_HALT: begin
          halted     = 1'b1;
          next_state = S_HALT;
        end
        default: next_state = S_IF;
      endcase
    end
    count_en = pc_write | ((state == S_ID) && (next_state == S_HALT) && !reset);
  end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm: walks every instruction class through its
// state sequence and checks all control outputs and the retired counter each cycle.
module tb_multicycle_control_fsm;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;
  localparam logic [6:0] OP_BAD    = 7'b0000000;

  logic        clk = 1'b0;
  logic        reset, bcond, halt_req, mem_ready;
  logic [6:0]  opcode;
  logic        mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_out_write;
  logic        reg_write, pc_write, alu_src_a, alu_sel, halted;
  logic [1:0]  pc_source, alu_src_b, wb_sel;
  logic [31:0] retired;

  logic        mem_read4, mem_write4, i_or_d4, ir_write4, mdr_write4, alu_out_write4;
  logic        reg_write4, pc_write4, alu_src_a4, alu_sel4, halted4;
  logic [1:0]  pc_source4, alu_src_b4, wb_sel4;
  logic [3:0]  retired4;

  int          n_cmp = 0;
  int          n_bad = 0;
  logic [31:0] exp_ret = '0;
  logic [16:0] obs;

  always #5 clk = ~clk;

  multicycle_control_fsm #(.CNT_W(32)) dut (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .mem_read(mem_read), .mem_write(mem_write), .i_or_d(i_or_d),
    .ir_write(ir_write), .mdr_write(mdr_write), .alu_out_write(alu_out_write),
    .reg_write(reg_write), .pc_write(pc_write), .pc_source(pc_source),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_sel(alu_sel), .wb_sel(wb_sel),
    .halted(halted), .retired(retired)
  );

  // Narrow-counter copy sharing the same stimulus, used to see the counter wrap.
  multicycle_control_fsm #(.CNT_W(4)) dut4 (
    .clk(clk), .reset(reset), .opcode(opcode), .bcond(bcond), .halt_req(halt_req),
    .mem_ready(mem_ready), .mem_read(mem_read4), .mem_write(mem_write4), .i_or_d(i_or_d4),
    .ir_write(ir_write4), .mdr_write(mdr_write4), .alu_out_write(alu_out_write4),
    .reg_write(reg_write4), .pc_write(pc_write4), .pc_source(pc_source4),
    .alu_src_a(alu_src_a4), .alu_src_b(alu_src_b4), .alu_sel(alu_sel4), .wb_sel(wb_sel4),
    .halted(halted4), .retired(retired4)
  );

  assign obs = {mem_read, mem_write, i_or_d, ir_write, mdr_write, alu_out_write, reg_write,
                pc_write, pc_source, alu_src_a, alu_src_b, alu_sel, wb_sel, halted};

  function automatic logic [16:0] ctl(input int mr, input int mw, input int iod, input int irw,
                                      input int mdrw, input int aow, input int rw, input int pcw,
                                      input int pcs, input int sa, input int sb, input int as,
                                      input int wb, input int h);
    return {mr[0], mw[0], iod[0], irw[0], mdrw[0], aow[0], rw[0], pcw[0], pcs[1:0], sa[0],
            sb[1:0], as[0], wb[1:0], h[0]};
  endfunction

  task automatic check_output(input string tag, input logic [16:0] want);
    n_cmp++;
    assert (obs === want) else begin
      n_bad++;
      $error("[TB] FAIL %s ctl got %b want %b", tag, obs, want);
    end
    n_cmp++;
    assert (retired === exp_ret) else begin
      n_bad++;
      $error("[TB] FAIL %s retired got %0d want %0d", tag, retired, exp_ret);
    end
    n_cmp++;
    assert (retired4 === exp_ret[3:0]) else begin
      n_bad++;
      $error("[TB] FAIL %s retired4 got %0d want %0d", tag, retired4, exp_ret[3:0]);
    end
  endtask

  // One clock cycle: drive inputs, check outputs mid-cycle, then advance past the edge.
  task automatic apply_stimulus(input string tag, input logic [6:0] op, input logic bc,
                                input logic hr, input logic rdy, input logic rst,
                                input logic [16:0] want, input bit commit);
    opcode    = op;
    bcond     = bc;
    halt_req  = hr;
    mem_ready = rdy;
    reset     = rst;
    #1;
    check_output(tag, want);
    if (commit) exp_ret = exp_ret + 32'd1;
    @(posedge clk);
    #1;
    if (rst) exp_ret = '0;
  endtask

  initial begin
    logic [16:0] v_zero, v_if, v_if_wait, v_id, v_id_nop, v_ex_r, v_ex_i, v_ex_ls;
    logic [16:0] v_ex_br1, v_ex_br0, v_mem_ldw, v_mem_ld, v_mem_st, v_wb_r, v_wb_ld;
    logic [16:0] v_wb_j, v_halt;
    v_zero    = '0;
    v_if      = ctl(1,0,0,1,0,0,0,0,0,0,0,0,0,0);
    v_if_wait = ctl(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
    v_id      = ctl(0,0,0,0,0,1,0,0,0,0,1,0,0,0);
    v_id_nop  = ctl(0,0,0,0,0,1,0,1,0,0,1,0,0,0);
    v_ex_r    = ctl(0,0,0,0,0,1,0,0,0,1,0,1,0,0);
    v_ex_i    = ctl(0,0,0,0,0,1,0,0,0,1,1,1,0,0);
    v_ex_ls   = ctl(0,0,0,0,0,1,0,0,0,1,1,0,0,0);
    v_ex_br1  = ctl(0,0,0,0,0,0,0,1,2,1,0,1,0,0);
    v_ex_br0  = ctl(0,0,0,0,0,0,0,1,0,1,0,1,0,0);
    v_mem_ldw = ctl(1,0,1,0,0,0,0,0,0,0,0,0,0,0);
    v_mem_ld  = ctl(1,0,1,0,1,0,0,0,0,0,0,0,0,0);
    v_mem_st  = ctl(0,1,1,0,0,0,0,1,0,0,0,0,0,0);
    v_wb_r    = ctl(0,0,0,0,0,0,1,1,0,0,0,0,0,0);
    v_wb_ld   = ctl(0,0,0,0,0,0,1,1,0,0,0,0,1,0);
    v_wb_j    = ctl(0,0,0,0,0,0,1,1,2,0,0,0,2,0);
    v_halt    = ctl(0,0,0,0,0,0,0,0,0,0,0,0,0,1);

    opcode = OP_R; bcond = 0; halt_req = 0; mem_ready = 1; reset = 1;
    @(posedge clk);
    #1;
    apply_stimulus("reset", OP_R, 0, 0, 1, 1, v_zero, 0);

    for (int i = 0; i < 3; i++) begin
      apply_stimulus("r_if", OP_R, 0, 0, 1, 0, v_if, 0);
      apply_stimulus("r_id", OP_R, 0, 0, 1, 0, v_id, 0);
      apply_stimulus("r_ex", OP_R, 0, 0, 1, 0, v_ex_r, 0);
      apply_stimulus("r_wb", OP_R, 0, 0, 1, 0, v_wb_r, 1);
    end

    apply_stimulus("ld_if",    OP_LOAD, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("ld_id",    OP_LOAD, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("ld_ex",    OP_LOAD, 0, 0, 1, 0, v_ex_ls, 0);
    apply_stimulus("ld_memw0", OP_LOAD, 0, 0, 0, 0, v_mem_ldw, 0);
    apply_stimulus("ld_memw1", OP_LOAD, 0, 0, 0, 0, v_mem_ldw, 0);
    apply_stimulus("ld_mem",   OP_LOAD, 0, 0, 1, 0, v_mem_ld, 0);
    apply_stimulus("ld_wb",    OP_LOAD, 0, 0, 1, 0, v_wb_ld, 1);

    apply_stimulus("br1_if", OP_BRANCH, 1, 0, 1, 0, v_if, 0);
    apply_stimulus("br1_id", OP_BRANCH, 1, 0, 1, 0, v_id, 0);
    apply_stimulus("br1_ex", OP_BRANCH, 1, 0, 1, 0, v_ex_br1, 1);
    apply_stimulus("br0_if", OP_BRANCH, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("br0_id", OP_BRANCH, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("br0_ex", OP_BRANCH, 0, 0, 1, 0, v_ex_br0, 1);

    apply_stimulus("jal_if",  OP_JAL,  0, 0, 1, 0, v_if, 0);
    apply_stimulus("jal_id",  OP_JAL,  0, 0, 1, 0, v_id, 0);
    apply_stimulus("jal_wb",  OP_JAL,  0, 0, 1, 0, v_wb_j, 1);
    apply_stimulus("jalr_if", OP_JALR, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("jalr_id", OP_JALR, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("jalr_ex", OP_JALR, 0, 0, 1, 0, v_ex_ls, 0);
    apply_stimulus("jalr_wb", OP_JALR, 0, 0, 1, 0, v_wb_j, 1);

    apply_stimulus("i_if", OP_I, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("i_id", OP_I, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("i_ex", OP_I, 0, 0, 1, 0, v_ex_i, 0);
    apply_stimulus("i_wb", OP_I, 0, 0, 1, 0, v_wb_r, 1);

    apply_stimulus("st_ifw", OP_STORE, 0, 0, 0, 0, v_if_wait, 0);
    apply_stimulus("st_if",  OP_STORE, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("st_id",  OP_STORE, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("st_ex",  OP_STORE, 0, 0, 1, 0, v_ex_ls, 0);
    apply_stimulus("st_mem", OP_STORE, 0, 0, 1, 0, v_mem_st, 1);

    apply_stimulus("bad_if", OP_BAD,   0, 0, 1, 0, v_if, 0);
    apply_stimulus("bad_id", OP_BAD,   0, 0, 1, 0, v_id_nop, 1);
    apply_stimulus("ec0_if", OP_ECALL, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("ec0_id", OP_ECALL, 0, 0, 1, 0, v_id_nop, 1);

    apply_stimulus("ec1_if", OP_ECALL, 0, 1, 1, 0, v_if, 0);
    apply_stimulus("ec1_id", OP_ECALL, 0, 1, 1, 0, v_id, 1);
    for (int i = 0; i < 20; i++)
      apply_stimulus("halt", (i % 2 == 0) ? OP_R : OP_STORE, 1, 1, 1, 0, v_halt, 0);
    apply_stimulus("halt_rst", OP_ECALL, 0, 1, 1, 1, v_zero, 0);

    apply_stimulus("r2_if", OP_R, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("r2_id", OP_R, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("r2_ex", OP_R, 0, 0, 1, 0, v_ex_r, 0);
    apply_stimulus("r2_wb", OP_R, 0, 0, 1, 0, v_wb_r, 1);
    apply_stimulus("str_if",  OP_STORE, 0, 0, 1, 0, v_if, 0);
    apply_stimulus("str_id",  OP_STORE, 0, 0, 1, 0, v_id, 0);
    apply_stimulus("str_ex",  OP_STORE, 0, 0, 1, 0, v_ex_ls, 0);
    apply_stimulus("str_rst", OP_STORE, 0, 0, 1, 1, v_zero, 0);

    for (int i = 0; i < 17; i++) begin
      apply_stimulus("nop_if", OP_BAD, 0, 0, 1, 0, v_if, 0);
      apply_stimulus("nop_id", OP_BAD, 0, 0, 1, 0, v_id_nop, 1);
    end
    #1;
    check_output("wrap_end", v_if);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
